// File: rtl/decode_cycle_if.sv
// Bundle between the decode stage and its neighbours: fetch-side instruction/PCs,
// writeback register-write port, D/E pipeline controls and the registered D/E outputs.
interface decode_cycle_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic [31:0]     InstrD;
  logic [XLEN-1:0] PCD;
  logic [XLEN-1:0] PCPlus4D;
  logic            RegWriteW;
  logic [AW-1:0]   RDW;
  logic [XLEN-1:0] ResultW;
  logic            EnE;
  logic            FlushE;

  logic            RegWriteE;
  logic            MemWriteE;
  logic            JumpE;
  logic            BranchE;
  logic            ALUSrcE;
  logic [1:0]      ResultSrcE;
  logic [2:0]      ALUControlE;
  logic [XLEN-1:0] RD1E;
  logic [XLEN-1:0] RD2E;
  logic [XLEN-1:0] ImmExtE;
  logic [AW-1:0]   RS1E;
  logic [AW-1:0]   RS2E;
  logic [AW-1:0]   RD_E;
  logic [XLEN-1:0] PCE;
  logic [XLEN-1:0] PCPlus4E;

  modport master (
    output InstrD, PCD, PCPlus4D, RegWriteW, RDW, ResultW, EnE, FlushE,
    input  RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE,
    input  RD1E, RD2E, ImmExtE, RS1E, RS2E, RD_E, PCE, PCPlus4E
  );

  modport slave (
    input  InstrD, PCD, PCPlus4D, RegWriteW, RDW, ResultW, EnE, FlushE,
    output RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE,
    output RD1E, RD2E, ImmExtE, RS1E, RS2E, RD_E, PCE, PCPlus4E
  );
endinterface

// File: rtl/decode_cycle.sv
// RV32I decode stage: control/ALU decode, immediate generation, register file with
// writeback bypass, and the D/E pipeline register with flush/stall.
module decode_cycle #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic          clk,
  input  logic          rst,
  decode_cycle_if.slave bus
);
  localparam int AW = 5;

  typedef enum logic [1:0] {IMM_I = 2'b00, IMM_S = 2'b01, IMM_B = 2'b10, IMM_J = 2'b11} imm_src_e;

  typedef struct packed {
    logic            reg_write;
    logic            mem_write;
    logic            jump;
    logic            branch;
    logic            alu_src;
    logic [1:0]      result_src;
    logic [2:0]      alu_control;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
  } de_t;

  logic [6:0]    op;
  logic [2:0]    funct3;
  logic          funct7b5;
  logic [AW-1:0] rs1, rs2, rd;

  assign op       = bus.InstrD[6:0];
  assign rd       = bus.InstrD[11:7];
  assign funct3   = bus.InstrD[14:12];
  assign rs1      = bus.InstrD[19:15];
  assign rs2      = bus.InstrD[24:20];
  assign funct7b5 = bus.InstrD[30];

  logic     ctl_reg_write, ctl_mem_write, ctl_jump, ctl_branch, ctl_alu_src;
  logic [1:0] ctl_result_src;
  logic [1:0] alu_op;
  imm_src_e   imm_src;
  logic [2:0] alu_control;
  logic [XLEN-1:0] imm_ext;

  always_comb begin
    ctl_reg_write  = 1'b0;
    ctl_mem_write  = 1'b0;
    ctl_jump       = 1'b0;
    ctl_branch     = 1'b0;
    ctl_alu_src    = 1'b0;
    ctl_result_src = 2'b00;
    alu_op         = 2'b00;
    imm_src        = IMM_I;
    case (op)
      7'b0000011: begin
        ctl_reg_write  = 1'b1;
        ctl_alu_src    = 1'b1;
        ctl_result_src = 2'b01;
      end
      7'b0100011: begin
        ctl_mem_write = 1'b1;
        ctl_alu_src   = 1'b1;
        imm_src       = IMM_S;
      end
      7'b0110011: begin
        ctl_reg_write = 1'b1;
        alu_op        = 2'b10;
      end
      7'b1100011: begin
        ctl_branch = 1'b1;
        imm_src    = IMM_B;
        alu_op     = 2'b01;
      end
      7'b0010011: begin
        ctl_reg_write = 1'b1;
        ctl_alu_src   = 1'b1;
        alu_op        = 2'b10;
      end
      7'b1101111: begin
        ctl_reg_write  = 1'b1;
        ctl_jump       = 1'b1;
        imm_src        = IMM_J;
        ctl_result_src = 2'b10;
      end
      default: ;
    endcase
  end

  // Only R-type (op[5]=1) may select subtract through funct7; addi never does.
  always_comb begin
    alu_control = 3'b000;
    case (alu_op)
      2'b01: alu_control = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  alu_control = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alu_control = 3'b101;
          3'b110:  alu_control = 3'b011;
          3'b111:  alu_control = 3'b010;
          default: alu_control = 3'b000;
        endcase
      end
      default: alu_control = 3'b000;
    endcase
  end

  always_comb begin
    imm_ext = {{(XLEN-12){bus.InstrD[31]}}, bus.InstrD[31:20]};
    case (imm_src)
      IMM_S: imm_ext = {{(XLEN-12){bus.InstrD[31]}}, bus.InstrD[31:25], bus.InstrD[11:7]};
      IMM_B: imm_ext = {{(XLEN-12){bus.InstrD[31]}}, bus.InstrD[7], bus.InstrD[30:25],
                        bus.InstrD[11:8], 1'b0};
      IMM_J: imm_ext = {{(XLEN-20){bus.InstrD[31]}}, bus.InstrD[19:12], bus.InstrD[20],
                        bus.InstrD[30:21], 1'b0};
      default: ;
    endcase
  end

  logic [XLEN-1:0] regs_q [NREGS];

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_rf
    always_ff @(posedge clk) begin
      if (!rst) begin
        regs_q[gi] <= '0;
      end else if (bus.RegWriteW && (gi != 0) && (bus.RDW == AW'(gi))) begin
        regs_q[gi] <= bus.ResultW;
      end
    end
  end

  // Same-cycle writeback is forwarded so the D/E register captures the new value.
  logic [XLEN-1:0] rd1, rd2;

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (rs1 != '0) begin
      rd1 = (bus.RegWriteW && bus.RDW == rs1) ? bus.ResultW : regs_q[rs1];
    end
    if (rs2 != '0) begin
      rd2 = (bus.RegWriteW && bus.RDW == rs2) ? bus.ResultW : regs_q[rs2];
    end
  end

  de_t de_q, de_d;

  always_comb begin
    de_d = de_q;
    if (bus.FlushE) begin
      de_d = '0;
    end else if (bus.EnE) begin
      de_d.reg_write   = ctl_reg_write;
      de_d.mem_write   = ctl_mem_write;
      de_d.jump        = ctl_jump;
      de_d.branch      = ctl_branch;
      de_d.alu_src     = ctl_alu_src;
      de_d.result_src  = ctl_result_src;
      de_d.alu_control = alu_control;
      de_d.rd1         = rd1;
      de_d.rd2         = rd2;
      de_d.imm         = imm_ext;
      de_d.rs1         = rs1;
      de_d.rs2         = rs2;
      de_d.rd          = rd;
      de_d.pc          = bus.PCD;
      de_d.pc4         = bus.PCPlus4D;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      de_q <= '0;
    end else begin
      de_q <= de_d;
    end
  end

  assign bus.RegWriteE   = de_q.reg_write;
  assign bus.MemWriteE   = de_q.mem_write;
  assign bus.JumpE       = de_q.jump;
  assign bus.BranchE     = de_q.branch;
  assign bus.ALUSrcE     = de_q.alu_src;
  assign bus.ResultSrcE  = de_q.result_src;
  assign bus.ALUControlE = de_q.alu_control;
  assign bus.RD1E        = de_q.rd1;
  assign bus.RD2E        = de_q.rd2;
  assign bus.ImmExtE     = de_q.imm;
  assign bus.RS1E        = de_q.rs1;
  assign bus.RS2E        = de_q.rs2;
  assign bus.RD_E        = de_q.rd;
  assign bus.PCE         = de_q.pc;
  assign bus.PCPlus4E    = de_q.pc4;
endmodule

// File: tb/tb_decode_cycle.sv
// Scoreboard bench for decode_cycle: directed instructions push hand-computed D/E
// contents; a monitor pops one entry per cycle after the edge and compares.
module tb_decode_cycle;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  decode_cycle_if #(.XLEN(32), .AW(5)) bus ();

  decode_cycle #(.XLEN(32), .NREGS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       tag;
    logic [15:0] mask;
    logic        rw, mw, jmp, br, asrc;
    logic [1:0]  rsrc;
    logic [2:0]  aluc;
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] pc, pc4;
  } exp_t;

  localparam logic [15:0] M_ALL   = 16'h7FFF;
  localparam logic [15:0] M_NOIMM = 16'h7DFF;
  localparam logic [15:0] M_CTL   = 16'h007F;

  localparam logic [31:0] ADD = 32'h002081B3;
  localparam logic [31:0] LW  = 32'hFFC12283;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   n_txn = 0;

  function automatic exp_t mk(string tag, logic [15:0] mask, logic rw, logic mw, logic jmp,
                              logic br, logic asrc, logic [1:0] rsrc, logic [2:0] aluc,
                              logic [31:0] rd1, logic [31:0] rd2, logic [31:0] imm,
                              logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                              logic [31:0] pc, logic [31:0] pc4);
    exp_t e;
    e.tag = tag;  e.mask = mask;
    e.rw = rw;    e.mw = mw;   e.jmp = jmp; e.br = br; e.asrc = asrc;
    e.rsrc = rsrc; e.aluc = aluc;
    e.rd1 = rd1;  e.rd2 = rd2; e.imm = imm;
    e.rs1 = rs1;  e.rs2 = rs2; e.rd = rd;
    e.pc = pc;    e.pc4 = pc4;
    return e;
  endfunction

  function automatic exp_t zero(string tag);
    return mk(tag, M_ALL, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic apply(input logic r, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] pc4, input logic ww, input logic [4:0] rdw,
                       input logic [31:0] resw, input logic en, input logic fl, input exp_t e);
    @(negedge clk);
    rst          = r;
    bus.InstrD   = ins;
    bus.PCD      = pc;
    bus.PCPlus4D = pc4;
    bus.RegWriteW = ww;
    bus.RDW      = rdw;
    bus.ResultW  = resw;
    bus.EnE      = en;
    bus.FlushE   = fl;
    sb_q.push_back(e);
  endtask

  task automatic chk(input string tag, input string fld, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got 0x%08h, expected 0x%08h", tag, fld, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    int   bad0;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        bad0 = n_bad;
        if (e.mask[0])  chk(e.tag, "RegWriteE",   32'(bus.RegWriteE),   32'(e.rw));
        if (e.mask[1])  chk(e.tag, "MemWriteE",   32'(bus.MemWriteE),   32'(e.mw));
        if (e.mask[2])  chk(e.tag, "JumpE",       32'(bus.JumpE),       32'(e.jmp));
        if (e.mask[3])  chk(e.tag, "BranchE",     32'(bus.BranchE),     32'(e.br));
        if (e.mask[4])  chk(e.tag, "ALUSrcE",     32'(bus.ALUSrcE),     32'(e.asrc));
        if (e.mask[5])  chk(e.tag, "ResultSrcE",  32'(bus.ResultSrcE),  32'(e.rsrc));
        if (e.mask[6])  chk(e.tag, "ALUControlE", 32'(bus.ALUControlE), 32'(e.aluc));
        if (e.mask[7])  chk(e.tag, "RD1E",        bus.RD1E,             e.rd1);
        if (e.mask[8])  chk(e.tag, "RD2E",        bus.RD2E,             e.rd2);
        if (e.mask[9])  chk(e.tag, "ImmExtE",     bus.ImmExtE,          e.imm);
        if (e.mask[10]) chk(e.tag, "RS1E",        32'(bus.RS1E),        32'(e.rs1));
        if (e.mask[11]) chk(e.tag, "RS2E",        32'(bus.RS2E),        32'(e.rs2));
        if (e.mask[12]) chk(e.tag, "RD_E",        32'(bus.RD_E),        32'(e.rd));
        if (e.mask[13]) chk(e.tag, "PCE",         bus.PCE,              e.pc);
        if (e.mask[14]) chk(e.tag, "PCPlus4E",    bus.PCPlus4E,         e.pc4);
        n_txn++;
        $display("txn %0d %-12s field errors %0d", n_txn, e.tag, n_bad - bad0);
      end
    end
  end

  initial begin
    exp_t v;
    rst = 1'b0;
    bus.InstrD = ADD;  bus.PCD = 32'h10; bus.PCPlus4D = 32'h14;
    bus.RegWriteW = 1'b0; bus.RDW = '0; bus.ResultW = '0;
    bus.EnE = 1'b1; bus.FlushE = 1'b0;

    // reset wins over a concurrent writeback to x1
    apply(0, ADD, 32'h10, 32'h14, 1, 5'd1, 32'h99, 1, 0, zero("rst0"));
    apply(0, ADD, 32'h10, 32'h14, 1, 5'd1, 32'h99, 1, 0, zero("rst1"));
    apply(1, ADD, 32'h08, 32'h0C, 0, 5'd0, 0, 1, 0,
          mk("x1_post_rst", M_NOIMM, 1,0,0,0,0, 2'b00, 3'b000, 0, 0, 0, 1, 2, 3, 32'h08, 32'h0C));

    apply(1, 32'h0, 0, 0, 1, 5'd1, 32'd5, 1, 0, zero("wr_x1"));
    apply(1, 32'h0, 0, 0, 1, 5'd2, 32'd7, 1, 0, zero("wr_x2"));
    apply(1, ADD, 32'h10, 32'h14, 0, 5'd0, 0, 1, 0,
          mk("add", M_NOIMM, 1,0,0,0,0, 2'b00, 3'b000, 5, 7, 0, 1, 2, 3, 32'h10, 32'h14));
    apply(1, 32'h40208333, 32'h18, 32'h1C, 0, 5'd0, 0, 1, 0,
          mk("sub", M_NOIMM, 1,0,0,0,0, 2'b00, 3'b001, 5, 7, 0, 1, 2, 6, 32'h18, 32'h1C));
    apply(1, 32'h0020E4B3, 32'h1C, 32'h20, 0, 5'd0, 0, 1, 0,
          mk("or", M_NOIMM, 1,0,0,0,0, 2'b00, 3'b011, 5, 7, 0, 1, 2, 9, 32'h1C, 32'h20));
    apply(1, 32'h0020F4B3, 32'h1C, 32'h20, 0, 5'd0, 0, 1, 0,
          mk("and", M_NOIMM, 1,0,0,0,0, 2'b00, 3'b010, 5, 7, 0, 1, 2, 9, 32'h1C, 32'h20));

    apply(1, 32'h0, 0, 0, 1, 5'd2, 32'h100, 1, 0, zero("wr_x2b"));
    apply(1, LW, 32'h20, 32'h24, 0, 5'd0, 0, 1, 0,
          mk("lw", M_ALL, 1,0,0,0,1, 2'b01, 3'b000, 32'h100, 0, 32'hFFFFFFFC, 2, 28, 5, 32'h20, 32'h24));
    apply(1, 32'h00208463, 32'h24, 32'h28, 0, 5'd0, 0, 1, 0,
          mk("beq", M_ALL, 0,0,0,1,0, 2'b00, 3'b001, 5, 32'h100, 32'h8, 1, 2, 8, 32'h24, 32'h28));
    apply(1, 32'hFE000EE3, 32'h28, 32'h2C, 0, 5'd0, 0, 1, 0,
          mk("beq_neg", M_ALL, 0,0,0,1,0, 2'b00, 3'b001, 0, 0, 32'hFFFFFFFC, 0, 0, 29, 32'h28, 32'h2C));
    apply(1, 32'h0020A423, 32'h2C, 32'h30, 0, 5'd0, 0, 1, 0,
          mk("sw", M_ALL, 0,1,0,0,1, 2'b00, 3'b000, 5, 32'h100, 32'h8, 1, 2, 8, 32'h2C, 32'h30));
    apply(1, 32'hFE20AFA3, 32'h30, 32'h34, 0, 5'd0, 0, 1, 0,
          mk("sw_neg", M_ALL, 0,1,0,0,1, 2'b00, 3'b000, 5, 32'h100, 32'hFFFFFFFF, 1, 2, 31, 32'h30, 32'h34));
    apply(1, 32'hFFF0A393, 32'h34, 32'h38, 0, 5'd0, 0, 1, 0,
          mk("slti", M_ALL, 1,0,0,0,1, 2'b00, 3'b101, 5, 0, 32'hFFFFFFFF, 1, 31, 7, 32'h34, 32'h38));
    apply(1, 32'h40008413, 32'h38, 32'h3C, 0, 5'd0, 0, 1, 0,
          mk("addi_b30", M_ALL, 1,0,0,0,1, 2'b00, 3'b000, 5, 0, 32'h400, 1, 0, 8, 32'h38, 32'h3C));
    apply(1, 32'h001000EF, 32'h3C, 32'h40, 0, 5'd0, 0, 1, 0,
          mk("jal", M_ALL, 1,0,1,0,0, 2'b10, 3'b000, 0, 5, 32'h800, 0, 1, 1, 32'h3C, 32'h40));
    apply(1, 32'hFFDFF06F, 32'h40, 32'h44, 0, 5'd0, 0, 1, 0,
          mk("jal_neg", M_ALL, 1,0,1,0,0, 2'b10, 3'b000, 0, 0, 32'hFFFFFFFC, 31, 29, 0, 32'h40, 32'h44));

    apply(1, ADD, 32'h30, 32'h34, 1, 5'd1, 32'hDEADBEEF, 1, 0,
          mk("bypass_rs1", M_NOIMM, 1,0,0,0,0, 2'b00, 3'b000, 32'hDEADBEEF, 32'h100, 0, 1, 2, 3, 32'h30, 32'h34));
    apply(1, ADD, 32'h34, 32'h38, 1, 5'd2, 32'h77, 1, 0,
          mk("bypass_rs2", M_NOIMM, 1,0,0,0,0, 2'b00, 3'b000, 32'hDEADBEEF, 32'h77, 0, 1, 2, 3, 32'h34, 32'h38));
    apply(1, 32'h00000233, 32'h38, 32'h3C, 1, 5'd0, 32'h55, 1, 0,
          mk("x0_wr", M_NOIMM, 1,0,0,0,0, 2'b00, 3'b000, 0, 0, 0, 0, 0, 4, 32'h38, 32'h3C));
    apply(1, 32'h00000233, 32'h3C, 32'h40, 0, 5'd0, 0, 1, 0,
          mk("x0_rd", M_NOIMM, 1,0,0,0,0, 2'b00, 3'b000, 0, 0, 0, 0, 0, 4, 32'h3C, 32'h40));

    // stall holds D/E while the register file still takes the writeback
    v = mk("pre_stall", M_NOIMM, 1,0,0,0,0, 2'b00, 3'b000, 32'hDEADBEEF, 32'h77, 0, 1, 2, 3, 32'h40, 32'h44);
    apply(1, ADD, 32'h40, 32'h44, 0, 5'd0, 0, 1, 0, v);
    v.tag = "stall1";
    apply(1, LW, 32'h50, 32'h54, 1, 5'd1, 32'h1234, 0, 0, v);
    v.tag = "stall2";
    apply(1, 32'h0020A423, 32'h58, 32'h5C, 0, 5'd0, 0, 0, 0, v);
    apply(1, ADD, 32'h60, 32'h64, 0, 5'd0, 0, 1, 0,
          mk("post_stall", M_NOIMM, 1,0,0,0,0, 2'b00, 3'b000, 32'h1234, 32'h77, 0, 1, 2, 3, 32'h60, 32'h64));

    apply(1, LW, 32'h70, 32'h74, 0, 5'd0, 0, 0, 1, zero("flush_stall"));
    apply(1, LW, 32'h78, 32'h7C, 0, 5'd0, 0, 1, 0,
          mk("lw2", M_ALL, 1,0,0,0,1, 2'b01, 3'b000, 32'h77, 0, 32'hFFFFFFFC, 2, 28, 5, 32'h78, 32'h7C));
    apply(1, ADD, 32'h7C, 32'h80, 0, 5'd0, 0, 1, 1, zero("flush_en"));
    apply(1, 32'hFFFFFFFF, 32'h80, 32'h84, 0, 5'd0, 0, 1, 0,
          mk("bad_op", M_CTL, 0,0,0,0,0, 2'b00, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0));

    apply(1, ADD, 32'h84, 32'h88, 0, 5'd0, 0, 1, 0,
          mk("pre_rst", M_NOIMM, 1,0,0,0,0, 2'b00, 3'b000, 32'h1234, 32'h77, 0, 1, 2, 3, 32'h84, 32'h88));
    apply(0, ADD, 32'h88, 32'h8C, 1, 5'd3, 32'hAA, 1, 0, zero("rst_mid"));
    apply(1, ADD, 32'h90, 32'h94, 0, 5'd0, 0, 1, 0,
          mk("post_rst", M_NOIMM, 1,0,0,0,0, 2'b00, 3'b000, 0, 0, 0, 1, 2, 3, 32'h90, 32'h94));

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    #2;
    if (sb_q.size() > 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
